// File: rtl/majority_pkg.sv
// Shared types and constants for the majority-voter sweep driver.
package majority_pkg;

    localparam int VOTE_W     = 5;
    localparam int N_VECT     = 32;
    localparam int MAJ_THRESH = 3;
    localparam int ERR_W      = 6;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        CHECK,
        NEXT,
        DONE
    } state_t;

endpackage

// File: rtl/majority_driver_edge_sync.sv
// Two-flop synchroniser for the start button plus rising-edge detector.
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic s1, s2, s3;
    logic filled, armed;

    // armed only after a genuine low is seen, so a level held across reset never fires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            filled <= 1'b0;
            armed  <= 1'b0;
        end else begin
            s1     <= din;
            s2     <= s1;
            s3     <= s2;
            filled <= 1'b1;
            armed  <= armed | (filled & ~s1);
        end
    end

    assign rise = s2 & ~s3 & armed;

endmodule

// File: rtl/majority_driver.sv
// Steps a 5-bit vote vector through all 32 values and counts voter mismatches.
module majority_driver
    import majority_pkg::*;
#(
    parameter int SETTLE = 4,
    parameter int DWELL  = 100_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dut_major,
    output logic [VOTE_W-1:0] vote,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]  DWELL_LAST  = CNT_W'(DWELL - 1);
    localparam logic [VOTE_W-1:0] VOTE_MAX    = VOTE_W'(N_VECT - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX     = ERR_W'(N_VECT);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [VOTE_W-1:0] vote_n;
    logic [ERR_W-1:0]  err_n;
    logic              busy_n, done_n, pass_n;
    logic              rise, expect_maj, step;

    edge_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (start),
        .rise  (rise)
    );

    assign expect_maj = ($countones(vote) >= MAJ_THRESH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            vote      <= '0;
            err_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            vote      <= vote_n;
            err_count <= err_n;
            busy      <= busy_n;
            done      <= done_n;
            pass      <= pass_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        vote_n  = vote;
        err_n   = err_count;
        busy_n  = busy;
        done_n  = done;
        pass_n  = pass;
        step    = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (rise) begin
                    state_n = DRIVE;
                    cnt_n   = '0;
                    vote_n  = '0;
                    err_n   = '0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    pass_n  = 1'b0;
                end
            end
            DRIVE: begin
                cnt_n = cnt + 1'b1;
                if (cnt == SETTLE_LAST)
                    state_n = CHECK;
            end
            CHECK: begin
                cnt_n = cnt + 1'b1;
                if ((dut_major != expect_maj) && (err_count != ERR_MAX))
                    err_n = err_count + 1'b1;
                // when DWELL == SETTLE+1 the check cycle is also the last dwell cycle
                if (cnt == DWELL_LAST)
                    step = 1'b1;
                else
                    state_n = NEXT;
            end
            NEXT: begin
                cnt_n = cnt + 1'b1;
                if (cnt == DWELL_LAST)
                    step = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        if (step) begin
            cnt_n = '0;
            if (vote == VOTE_MAX) begin
                state_n = DONE;
                busy_n  = 1'b0;
                done_n  = 1'b1;
                pass_n  = (err_n == '0);
            end else begin
                state_n = DRIVE;
                vote_n  = vote + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_majority_driver.sv
// Directed bench for majority_driver with SETTLE=4, DWELL=8.
module tb_majority_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       dut_major;
    logic [4:0] vote;
    logic       busy, done, pass;
    logic [5:0] err_count;

    int checks = 0;
    int errors = 0;
    int mode   = 0;

    always #5 clk = ~clk;

    majority_driver #(
        .SETTLE (4),
        .DWELL  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dut_major (dut_major),
        .vote      (vote),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count)
    );

    // voter under test: 0 ideal, 1 stuck-at-0, 2 wrong on 5'b00111 only
    always_comb begin
        dut_major = ($countones(vote) >= 3);
        if (mode == 1)
            dut_major = 1'b0;
        else if (mode == 2 && vote == 5'b00111)
            dut_major = ~dut_major;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_and_wait(output bit ok);
        ok = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 2) start = 1'b0;
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!ok) check("busy_timeout", 0, 1);
    endtask

    task automatic run_sweep(input int exp_err, input int pulse_vec);
        bit ok;
        pulse_and_wait(ok);
        if (!ok) return;
        check("entry_err", err_count, 0);
        check("entry_done", done, 0);
        check("entry_pass", pass, 0);
        check("entry_vote", vote, 0);
        for (int k = 0; k < 256; k++) begin
            if (k % 8 == 0) check("vote_step", vote, k / 8);
            if (k == 255) check("done_early", done, 0);
            if (pulse_vec >= 0 && k == pulse_vec * 8) start = 1'b1;
            if (pulse_vec >= 0 && k == pulse_vec * 8 + 3) start = 1'b0;
            @(negedge clk);
        end
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_err", err_count, exp_err);
        check("end_pass", pass, exp_err == 0);
        check("end_vote", vote, 31);
        repeat (4) @(negedge clk);
        check("hold_vote", vote, 31);
        check("hold_done", done, 1);
    endtask

    initial begin
        bit ok;
        repeat (3) @(negedge clk);
        check("rst_vote", vote, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_busy", busy, 0);

        mode = 0;
        run_sweep(0, -1);
        mode = 1;
        run_sweep(16, -1);
        mode = 2;
        run_sweep(1, -1);
        mode = 0;
        run_sweep(0, 10);

        mode = 1;
        pulse_and_wait(ok);
        if (ok) begin
            repeat (160) @(negedge clk);
            check("mid_vote", vote, 20);
            check("mid_err", err_count, 6);
        end
        start = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_vote", vote, 0);
        check("abort_busy", busy, 0);
        check("abort_err", err_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("held_busy", busy, 0);
        check("held_done", done, 0);
        check("held_pass", pass, 0);
        check("held_vote", vote, 0);
        check("held_err", err_count, 0);
        start = 1'b0;
        repeat (4) @(negedge clk);
        mode = 0;
        run_sweep(0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
